// File: rtl/uart_rx_pkt_parser.sv
// rtl/uart_rx_pkt_parser.sv - pops UART RX FIFO bytes, parses SOF|LEN|payload|CHK frames, streams payload out
module uart_rx_pkt_parser #(
    parameter logic [7:0] SOF_BYTE = 8'hA5,
    parameter int         MAX_LEN  = 16,
    parameter int         TIMEOUT  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    output logic       rd_en,
    input  logic [7:0] rx_data,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       pkt_last,
    input  logic       pkt_ready,
    output logic       pkt_done,
    output logic       pkt_ok,
    output logic       err_len,
    output logic       err_timeout,
    output logic       busy
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_pending;
    logic [7:0]    r_chk;
    logic [7:0]    w_chk_nx;
    logic [7:0]    r_rem;
    logic [7:0]    w_rem_nx;
    logic [TW-1:0] r_tmo_cnt;

    logic [7:0]    r_pkt_data;
    logic          r_pkt_valid;
    logic          r_pkt_last;
    logic          r_pkt_done;
    logic          r_pkt_ok;
    logic          r_err_len;
    logic          r_err_tmo;

    logic          w_hold;
    logic          w_rd_en;
    logic          w_tmo_cnt_en;
    logic          w_tmo_hit;
    logic          w_len_ok;
    logic          w_load;
    logic          w_done;
    logic          w_ok;
    logic          w_err_len;
    logic          w_err_tmo;

    // One byte in flight at most; the done cycle is skipped so the next SOF follows it.
    assign w_hold       = r_pkt_valid && !pkt_ready;
    assign w_rd_en      = !reset && !rx_empty && !r_pending && !w_hold && !r_pkt_done;
    assign w_tmo_cnt_en = (r_state != S_HUNT) && rx_empty && !r_pending && !w_hold;
    assign w_tmo_hit    = w_tmo_cnt_en && (r_tmo_cnt == TMO_LAST);
    assign w_len_ok     = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_chk_nx   = r_chk;
        w_rem_nx   = r_rem;
        w_load     = 1'b0;
        w_done     = 1'b0;
        w_ok       = 1'b0;
        w_err_len  = 1'b0;
        w_err_tmo  = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (r_pending && (rx_data == SOF_BYTE)) begin
                    w_state_nx = S_LEN;
                    w_chk_nx   = 8'd0;
                end
            end
            S_LEN: begin
                if (r_pending) begin
                    if (w_len_ok) begin
                        w_state_nx = S_PAYLOAD;
                        w_rem_nx   = rx_data;
                        w_chk_nx   = rx_data;
                    end else begin
                        w_state_nx = S_HUNT;
                        w_err_len  = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nx = S_HUNT;
                    w_err_tmo  = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (r_pending) begin
                    w_load   = 1'b1;
                    w_chk_nx = r_chk ^ rx_data;
                    w_rem_nx = r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        w_state_nx = S_CHK;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nx = S_HUNT;
                    w_err_tmo  = 1'b1;
                    w_done     = 1'b1;
                end
            end
            S_CHK: begin
                if (r_pending) begin
                    w_state_nx = S_HUNT;
                    w_done     = 1'b1;
                    w_ok       = (rx_data == r_chk);
                end else if (w_tmo_hit) begin
                    w_state_nx = S_HUNT;
                    w_err_tmo  = 1'b1;
                    w_done     = 1'b1;
                end
            end
            default: w_state_nx = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= 1'b0;
            r_chk       <= 8'd0;
            r_rem       <= 8'd0;
            r_tmo_cnt   <= '0;
            r_pkt_data  <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_last  <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_ok    <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_pending <= w_rd_en;
            r_chk     <= w_chk_nx;
            r_rem     <= w_rem_nx;
            if (w_rd_en || (r_state == S_HUNT)) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_cnt_en) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
            // A held payload byte survives an abort and drains normally.
            if (w_load) begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= rx_data;
                r_pkt_last  <= (r_rem == 8'd1);
            end else if (r_pkt_valid && pkt_ready) begin
                r_pkt_valid <= 1'b0;
                r_pkt_last  <= 1'b0;
            end
            r_pkt_done <= w_done;
            r_pkt_ok   <= w_ok;
            r_err_len  <= w_err_len;
            r_err_tmo  <= w_err_tmo;
        end
    end

    assign rd_en       = w_rd_en;
    assign pkt_data    = r_pkt_data;
    assign pkt_valid   = r_pkt_valid;
    assign pkt_last    = r_pkt_last;
    assign pkt_done    = r_pkt_done;
    assign pkt_ok      = r_pkt_ok;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_tmo;
    assign busy        = (r_state != S_HUNT);

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// tb/tb_uart_rx_pkt_parser.sv - table-driven and directed bench for uart_rx_pkt_parser
module tb_uart_rx_pkt_parser;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty;
    logic       rd_en;
    logic [7:0] rx_data = 8'd0;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_last;
    logic       pkt_ready = 1'b1;
    logic       pkt_done;
    logic       pkt_ok;
    logic       err_len;
    logic       err_timeout;
    logic       busy;

    uart_rx_pkt_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rd_en(rd_en), .rx_data(rx_data),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_len(err_len), .err_timeout(err_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: stimulus owns wr_ptr/mem, the read process owns rd_ptr
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic       flush = 1'b0;
    assign rx_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en) begin
            rx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
        end
    end

    // Output monitor, sampled on the falling edge
    logic [7:0] cap_data [256];
    logic       cap_last [256];
    int cap_n = 0, done_n = 0, ok_n = 0, errlen_n = 0, tmo_n = 0, rd_n = 0;

    always @(negedge clk) begin
        if (pkt_valid && pkt_ready) begin
            cap_data[cap_n & 255] <= pkt_data;
            cap_last[cap_n & 255] <= pkt_last;
            cap_n <= cap_n + 1;
        end
        if (pkt_done) done_n <= done_n + 1;
        if (pkt_done && pkt_ok) ok_n <= ok_n + 1;
        if (err_len) errlen_n <= errlen_n + 1;
        if (err_timeout) tmo_n <= tmo_n + 1;
        if (rd_en) rd_n <= rd_n + 1;
    end

    typedef struct packed {
        int              nin;
        logic [0:19][7:0] din;
        int              nout;
        logic [0:15][7:0] dout;
        logic [15:0]     lmask;
        int              ndone;
        int              nok;
        int              nerr;
    } vec_t;

    vec_t tv [7];
    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic run_vec(input int i);
        int b_cap, b_done, b_ok, b_err, b_tmo, got;
        b_cap = cap_n; b_done = done_n; b_ok = ok_n; b_err = errlen_n; b_tmo = tmo_n;
        for (int k = 0; k < tv[i].nin; k++) push(tv[i].din[k]);
        cycles(2 * tv[i].nin + 20);
        got = cap_n - b_cap;
        check($sformatf("v%0d_count", i), got, tv[i].nout);
        for (int k = 0; k < tv[i].nout; k++) begin
            if (k < got) begin
                check($sformatf("v%0d_data%0d", i, k), cap_data[(b_cap + k) & 255], tv[i].dout[k]);
                check($sformatf("v%0d_last%0d", i, k), cap_last[(b_cap + k) & 255], tv[i].lmask[k]);
            end
        end
        check($sformatf("v%0d_done", i), done_n - b_done, tv[i].ndone);
        check($sformatf("v%0d_ok", i), ok_n - b_ok, tv[i].nok);
        check($sformatf("v%0d_errlen", i), errlen_n - b_err, tv[i].nerr);
        check($sformatf("v%0d_tmo", i), tmo_n - b_tmo, 0);
        check($sformatf("v%0d_busy", i), busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b_cap, b_done, b_ok, b_tmo, b_rd;

        tv[0] = '0; tv[0].nin = 6; tv[0].din[0:5] = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        tv[0].nout = 3; tv[0].dout[0:2] = {8'h11, 8'h22, 8'h33}; tv[0].lmask = 16'h0004;
        tv[0].ndone = 1; tv[0].nok = 1;
        tv[1] = tv[0]; tv[1].din[5] = 8'h7E; tv[1].nok = 0;
        tv[2] = '0; tv[2].nin = 7; tv[2].din[0:6] = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5, 8'hA4};
        tv[2].nout = 1; tv[2].dout[0] = 8'hA5; tv[2].lmask = 16'h0001; tv[2].ndone = 1; tv[2].nok = 1;
        tv[3] = '0; tv[3].nin = 2; tv[3].din[0:1] = {8'hA5, 8'h00}; tv[3].nerr = 1;
        tv[4] = '0; tv[4].nin = 2; tv[4].din[0:1] = {8'hA5, 8'h11}; tv[4].nerr = 1;
        tv[5] = '0; tv[5].nin = 19; tv[5].din[0] = 8'hA5; tv[5].din[1] = 8'h10;
        for (int j = 0; j < 16; j++) begin
            tv[5].din[2 + j] = 8'(j);
            tv[5].dout[j] = 8'(j);
        end
        tv[5].din[18] = 8'h10; tv[5].nout = 16; tv[5].lmask = 16'h8000; tv[5].ndone = 1; tv[5].nok = 1;
        tv[6] = '0; tv[6].nin = 8;
        tv[6].din[0:7] = {8'hA5, 8'h01, 8'h42, 8'h43, 8'hA5, 8'h01, 8'h55, 8'h54};
        tv[6].nout = 2; tv[6].dout[0:1] = {8'h42, 8'h55}; tv[6].lmask = 16'h0003;
        tv[6].ndone = 2; tv[6].nok = 2;

        // Reset state with a byte waiting in the FIFO
        cycles(2);
        push(8'h5A);
        #1;
        check("reset_outputs",
              {24'd0, rd_en, pkt_valid, pkt_last, pkt_done, pkt_ok, err_len, err_timeout, busy}, 0);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        reset = 1'b0;
        cycles(2);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Inter-byte timeout mid-payload, then a clean frame
        b_cap = cap_n; b_done = done_n; b_ok = ok_n; b_tmo = tmo_n;
        push(8'hA5); push(8'h02); push(8'h11);
        cycles(20);
        check("tmo_early", tmo_n - b_tmo, 0);
        check("tmo_busy_wait", busy, 1);
        cycles(50);
        check("tmo_fired", tmo_n - b_tmo, 1);
        check("tmo_done", done_n - b_done, 1);
        check("tmo_ok", ok_n - b_ok, 0);
        check("tmo_payload", cap_n - b_cap, 1);
        check("tmo_busy", busy, 0);
        run_vec(0);

        // Downstream stall with the FIFO empty must not time out or fetch
        b_cap = cap_n; b_done = done_n; b_ok = ok_n;
        pkt_ready = 1'b0;
        push(8'hA5); push(8'h03); push(8'h11);
        cycles(10);
        check("stall_valid0", pkt_valid, 1);
        check("stall_data0", pkt_data, 8'h11);
        b_rd = rd_n; b_tmo = tmo_n;
        cycles(50);
        check("stall_rd", rd_n - b_rd, 0);
        check("stall_tmo", tmo_n - b_tmo, 0);
        check("stall_valid1", pkt_valid, 1);
        check("stall_data1", pkt_data, 8'h11);
        push(8'h22); push(8'h33); push(8'h03);
        pkt_ready = 1'b1;
        cycles(40);
        check("stall_count", cap_n - b_cap, 3);
        check("stall_byte2", cap_data[(b_cap + 2) & 255], 8'h33);
        check("stall_last", cap_last[(b_cap + 2) & 255], 1);
        check("stall_done", done_n - b_done, 1);
        check("stall_ok", ok_n - b_ok, 1);

        // Reset after two payload bytes
        b_cap = cap_n; b_done = done_n;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
        for (int t = 0; t < 100 && (cap_n - b_cap) < 2; t++) cycles(1);
        check("rst_prefix", cap_n - b_cap, 2);
        reset = 1'b1;
        #1;
        check("rst_outputs",
              {24'd0, rd_en, pkt_valid, pkt_last, pkt_done, pkt_ok, err_len, err_timeout, busy}, 0);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        reset = 1'b0;
        cycles(10);
        check("rst_no_done", done_n - b_done, 0);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
